// File: rtl/t07_immgen_pkg.sv
// Shared types for the immediate-decode queue: instruction formats, opcodes, queue entry.
package t07_immgen_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Immediate is stored in a separate XLEN-wide array, so the entry stays XLEN-independent.
  typedef struct packed {
    logic [31:0] instr;
    fmt_t        fmt;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/t07_imm_extract.sv
// Combinational immediate extractor: classifies an RV instruction and builds its XLEN-wide immediate.
module t07_imm_extract
  import t07_immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  fmt_t       fmt_d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign fmt    = fmt_d;

  always_comb begin
    imm     = '0;
    fmt_d   = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        // Shift amount width follows XLEN; instr[30] selects srai and is not part of the value.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_d = FMT_SHAMT;
          if (XLEN == 32) imm = XLEN'(instr[24:20]);
          else            imm = XLEN'(instr[25:20]);
        end else begin
          fmt_d = FMT_I;
          imm   = XLEN'($signed(instr[31:20]));
        end
      end
      OP_LOAD, OP_JALR, OP_SYS: begin
        fmt_d = FMT_I;
        imm   = XLEN'($signed(instr[31:20]));
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm   = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        fmt_d = FMT_B;
        imm   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm   = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OP_REG: begin
        fmt_d = FMT_R;
      end
      default: begin
        fmt_d   = FMT_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/t07_imm_decode_queue.sv
// Decodes immediates at fetch side and queues them in a DEPTH-entry FIFO toward execute.
// Optional perf counters (perf_pushed, perf_stall) when T07_IMMGEN_PERF_EN is defined.
module t07_imm_decode_queue
  import t07_immgen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef T07_IMMGEN_PERF_EN
  ,
  output logic [31:0]     perf_pushed,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  entry_t           meta_mem [DEPTH];
  logic [XLEN-1:0]  imm_mem  [DEPTH];

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;
  entry_t           wr_entry;
  entry_t           head;
  logic             push, pop;

  t07_imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry.instr   = in_instr;
  assign wr_entry.fmt     = fmt_t'(dec_fmt);
  assign wr_entry.illegal = dec_illegal;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_valid masks every head read.
  always_ff @(posedge clk) begin
    if (push) begin
      meta_mem[wr_ptr] <= wr_entry;
      imm_mem[wr_ptr]  <= dec_imm;
    end
  end

  assign head        = meta_mem[rd_ptr];
  assign out_instr   = out_valid ? head.instr       : '0;
  assign out_imm     = out_valid ? imm_mem[rd_ptr]  : '0;
  assign out_fmt     = out_valid ? head.fmt         : FMT_R;
  assign out_illegal = out_valid ? head.illegal     : 1'b0;

`ifdef T07_IMMGEN_PERF_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      perf_pushed <= '0;
      perf_stall  <= '0;
    end else begin
      if (push && perf_pushed != '1)
        perf_pushed <= perf_pushed + 1'b1;
      if (in_valid && !in_ready && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
